// File: rtl/tron_defs.sv
// Shared constants, colour codes and state encoding for the tron display path.
package tron_defs;

    localparam int unsigned NUM_REQ  = 5;
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_MAX    = SCREEN_W - 1;
    localparam int unsigned Y_MAX    = SCREEN_H - 1;

    localparam logic [2:0] C_BG    = 3'b000;
    localparam logic [2:0] C_P1    = 3'b001;
    localparam logic [2:0] C_P2    = 3'b010;
    localparam logic [2:0] C_P3    = 3'b100;
    localparam logic [2:0] C_P4    = 3'b110;
    localparam logic [2:0] C_TIMER = 3'b111;

    localparam logic [2:0] CLEAR_COLOUR = C_BG;

    localparam int unsigned REQ_P1    = 0;
    localparam int unsigned REQ_P2    = 1;
    localparam int unsigned REQ_P3    = 2;
    localparam int unsigned REQ_P4    = 3;
    localparam int unsigned REQ_TIMER = 4;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Next index in the circular search order.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/plot_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward, wrapping at num_req.
module rr_arbiter
    import tron_defs::*;
#(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    int unsigned cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = int'(last);
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_next(cand, NUM_REQ);
            if (!gnt_valid && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plot_scheduler.sv
// Shares the vga_adapter write port among pixel requesters and runs full-screen clear sweeps.
module plot_scheduler
    import tron_defs::*;
#(
    parameter int unsigned NUM_REQ      = tron_defs::NUM_REQ,
    parameter int unsigned X_MAX        = tron_defs::X_MAX,
    parameter int unsigned Y_MAX        = tron_defs::Y_MAX,
    parameter logic [2:0]  CLEAR_COLOUR = tron_defs::CLEAR_COLOUR
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_x,
    input  logic [NUM_REQ*7-1:0] req_y,
    input  logic [NUM_REQ*3-1:0] req_colour,
    output logic [NUM_REQ-1:0]   gnt,
    input  logic                 clear_start,
    output logic                 clear_busy,
    output logic                 clear_done,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]  X_LAST = 8'(X_MAX);
    localparam logic [6:0]  Y_LAST = 7'(Y_MAX);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [7:0]         cx_q, cx_d;
    logic [6:0]         cy_q, cy_d;
    logic               sweep_last_q, sweep_last_d;
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic [2:0]         colour_q, colour_d;
    logic               plot_q, plot_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req),
        .last      (last_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        sweep_last_d = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        gnt          = '0;

        unique case (state_q)
            ST_ARB: begin
                gnt = arb_gnt;
                if (arb_valid) begin
                    last_d   = arb_idx;
                    x_d      = req_x[8*int'(arb_idx) +: 8];
                    y_d      = req_y[7*int'(arb_idx) +: 7];
                    colour_d = req_colour[3*int'(arb_idx) +: 3];
                    plot_d   = 1'b1;
                end
                if (clear_start) begin
                    state_d = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                // One extra cycle after the final pixel is loaded lets it reach the
                // outputs before clear_done and the return to arbitration.
                if (sweep_last_q) begin
                    state_d = ST_ARB;
                    done_d  = 1'b1;
                end else begin
                    x_d      = cx_q;
                    y_d      = cy_q;
                    colour_d = CLEAR_COLOUR;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    if (cx_q == X_LAST) begin
                        cx_d = '0;
                        if (cy_q == Y_LAST) begin
                            cy_d         = '0;
                            sweep_last_d = 1'b1;
                        end else begin
                            cy_d = cy_q + 7'd1;
                        end
                    end else begin
                        cx_d = cx_q + 8'd1;
                    end
                end
            end

            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_ARB;
            last_q       <= IDX_W'(NUM_REQ - 1);
            cx_q         <= '0;
            cy_q         <= '0;
            sweep_last_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            sweep_last_q <= sweep_last_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// Self-checking bench for plot_scheduler against a pixel-index reference model.
module tb_plot_scheduler;

    localparam int N      = 5;
    localparam int W      = 160;
    localparam int H      = 120;
    localparam int PIXELS = W * H;

    logic           CLOCK_50 = 1'b0;
    logic           resetn;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_x;
    logic [N*7-1:0] req_y;
    logic [N*3-1:0] req_colour;
    logic [N-1:0]   gnt;
    logic           clear_start;
    logic           clear_busy;
    logic           clear_done;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [2:0]     colour;
    logic           plot;

    always #10 CLOCK_50 = ~CLOCK_50;

    plot_scheduler dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .req         (req),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_colour  (req_colour),
        .gnt         (gnt),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot)
    );

    int checks = 0;
    int errors = 0;

    int rx[N];
    int ry[N];
    int rc[N];
    bit pending[N];

    // Reference model: pending pixel expected on the outputs next cycle.
    int m_last;
    bit m_clear;
    int m_pix;
    int m_gidx;
    int e_x, e_y, e_c;
    bit e_plot, e_busy, e_done;

    int busy_cnt;
    int done_cnt;
    bit granted0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = N - 1;
        m_clear = 1'b0;
        m_pix   = 0;
        m_gidx  = -1;
        e_x = 0; e_y = 0; e_c = 0;
        e_plot = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_x"}, 32'(x), 32'(e_x));
        check({pfx, "_y"}, 32'(y), 32'(e_y));
        check({pfx, "_colour"}, 32'(colour), 32'(e_c));
        check({pfx, "_plot"}, 32'(plot), 32'(e_plot));
        check({pfx, "_busy"}, 32'(clear_busy), 32'(e_busy));
        check({pfx, "_done"}, 32'(clear_done), 32'(e_done));
    endtask

    // Called just after a falling edge with req/clear_start already set.
    task automatic cycle();
        int exp_gnt;
        for (int i = 0; i < N; i++) begin
            req_x[8*i +: 8]      = 8'(rx[i]);
            req_y[7*i +: 7]      = 7'(ry[i]);
            req_colour[3*i +: 3] = 3'(rc[i]);
        end
        #1;
        check_outputs("cyc");
        if (clear_busy === 1'b1) busy_cnt++;
        if (clear_done === 1'b1) done_cnt++;

        m_gidx = -1;
        if (!m_clear) begin
            for (int k = 1; k <= N; k++) begin
                if (m_gidx < 0 && req[(m_last + k) % N]) m_gidx = (m_last + k) % N;
            end
        end
        exp_gnt = (m_gidx < 0) ? 0 : (1 << m_gidx);
        check("gnt", 32'(gnt), 32'(exp_gnt));

        if (!m_clear) begin
            e_busy = 1'b0;
            e_done = 1'b0;
            if (m_gidx >= 0) begin
                m_last = m_gidx;
                e_x = rx[m_gidx]; e_y = ry[m_gidx]; e_c = rc[m_gidx];
                e_plot = 1'b1;
            end else begin
                e_plot = 1'b0;
            end
            if (clear_start) begin
                m_clear = 1'b1;
                m_pix   = 0;
            end
        end else if (m_pix < PIXELS) begin
            e_x = m_pix % W; e_y = m_pix / W; e_c = 0;
            e_plot = 1'b1; e_busy = 1'b1; e_done = 1'b0;
            m_pix++;
        end else begin
            e_plot = 1'b0; e_busy = 1'b0; e_done = 1'b1;
            m_clear = 1'b0;
        end
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        req = '0;
        clear_start = 1'b0;
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        check("rst_gnt", 32'(gnt), 32'd0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b1;
        req = '0;
        req_x = '0;
        req_y = '0;
        req_colour = '0;
        clear_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            rx[i] = 0; ry[i] = 0; rc[i] = 0; pending[i] = 1'b0;
        end
        model_reset();
        @(negedge CLOCK_50);

        // Single request after reset
        do_reset();
        rx[2] = 40; ry[2] = 30; rc[2] = 3'b100;
        req = 5'b00100;
        cycle();
        req = '0;
        cycle();
        cycle();

        // Round-robin fairness from reset
        do_reset();
        for (int i = 0; i < N; i++) begin
            rx[i] = 20 * i + 3; ry[i] = 11 * i + 1; rc[i] = i + 1;
        end
        req = 5'b11111;
        repeat (10) cycle();
        req = '0;
        cycle();

        // Pointer continuity: after granting 3, requester 0 wins over 3
        do_reset();
        req = 5'b01000;
        cycle();
        req = 5'b01001;
        cycle();
        req = 5'b01000;
        cycle();
        req = '0;
        cycle();

        // Randomized requesters that hold until granted
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    rx[i] = $urandom_range(0, 255);
                    ry[i] = $urandom_range(0, 127);
                    rc[i] = $urandom_range(0, 7);
                    req[i] = 1'b1;
                end
            end
            cycle();
            if (m_gidx >= 0) begin
                pending[m_gidx] = 1'b0;
                req[m_gidx] = 1'b0;
            end
        end
        req = '0;
        for (int i = 0; i < N; i++) pending[i] = 1'b0;
        cycle();

        // Clear sweep with a stray clear_start mid-way
        busy_cnt = 0;
        done_cnt = 0;
        clear_start = 1'b1;
        cycle();
        for (int j = 0; j < PIXELS + 4; j++) begin
            clear_start = (j == 500);
            cycle();
        end
        clear_start = 1'b0;
        check("sweep_busy_cycles", 32'(busy_cnt), 32'(PIXELS));
        check("sweep_done_pulses", 32'(done_cnt), 32'd1);

        // Clear versus requests: timer wins the start cycle, requester 0 waits
        rx[4] = 10; ry[4] = 119; rc[4] = 3'b111;
        rx[0] = 77; ry[0] = 55; rc[0] = 3'b001;
        req = 5'b10000;
        clear_start = 1'b1;
        cycle();
        clear_start = 1'b0;
        req = 5'b00001;
        granted0 = 1'b0;
        for (int j = 0; j < PIXELS + 8; j++) begin
            cycle();
            if (m_gidx == 0) begin
                req = '0;
                granted0 = 1'b1;
            end
        end
        check("req0_served", 32'(req), 32'd0);

        // Reset mid-clear, then a fresh sweep starts at the origin
        done_cnt = 0;
        clear_start = 1'b1;
        cycle();
        clear_start = 1'b0;
        repeat (1000) cycle();
        do_reset();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        clear_start = 1'b1;
        cycle();
        clear_start = 1'b0;
        repeat (6) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
